// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane synchronous FIFO: width functions and mode constants.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Ceiling log2; clog2_f(1) == 0.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ptr_w_f(input int unsigned depth);
    return (clog2_f(depth) < 1) ? 1 : clog2_f(depth);
  endfunction

  function automatic int unsigned lvl_w_f(input int unsigned depth);
    return clog2_f(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag control for fifo_sync_mc; supports non-power-of-two depths.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1,
  localparam int unsigned PW       = ptr_w_f(DEPTH),
  localparam int unsigned LW       = lvl_w_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          clr_err,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  if (!(DEPTH >= 2 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : gen_param_err
    $error("fifo_ptr_ctrl: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  localparam logic [PW-1:0] PtrMax = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LvlMax = LW'(DEPTH);
  localparam logic [LW-1:0] AfLvl  = LW'(AF_THRESH);
  localparam logic [LW-1:0] AeLvl  = LW'(AE_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  assign wr_acc = wr_req & ~full_q;
  assign rd_acc = rd_req & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    // Explicit wrap compare so any DEPTH works, not just powers of two.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Setting beats clearing when both happen in one cycle.
    if (wr_req && full_q)       ovf_d = 1'b1;
    else if (clr_err)           ovf_d = 1'b0;
    if (rd_req && empty_q)      unf_d = 1'b1;
    else if (clr_err)           unf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      // Flags come from the next level so they line up with level_q.
      full_q   <= (level_d == LvlMax);
      empty_q  <= (level_d == '0);
      af_q     <= (level_d >= AfLvl);
      ae_q     <= (level_d <= AeLvl);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: rtl/fifo_sync_mc.sv
// Multi-lane synchronous FIFO: NUM_CH lanes per entry, standard or first-word-fall-through read.
module fifo_sync_mc
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FWFT       = FIFO_STD,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  localparam int unsigned W         = NUM_CH * DATA_WIDTH,
  localparam int unsigned LW        = lvl_w_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [W-1:0]  data_in,
  input  logic          rd_req,
  output logic [W-1:0]  data_out,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam int unsigned PW = ptr_w_f(DEPTH);

  logic          wr_acc, rd_acc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  mem_q [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .AF_THRESH(AF_THRESH),
    .AE_THRESH(AE_THRESH)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .clr_err     (clr_err),
    .wr_acc      (wr_acc),
    .rd_acc      (rd_acc),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Storage is deliberately not reset; level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr] <= data_in;
  end

  if (FWFT == FIFO_FWFT) begin : gen_fwft
    logic unused_rd_acc;
    assign unused_rd_acc = rd_acc;
    // Masked while empty so stale or uninitialised storage never reaches the port.
    assign data_out = empty ? '0 : mem_q[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : gen_std
    logic [W-1:0] dout_q;
    logic         vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) dout_q <= mem_q[rd_ptr];
      end
    end

    assign data_out = dout_q;
    assign rd_valid = vld_q;
  end

endmodule

// File: tb/tb_fifo_sync_mc.sv
// Scoreboard bench: one standard and one FWFT instance share stimulus, checked against a queue model.
module tb_fifo_sync_mc;
  import fifo_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned NC    = 3;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AF    = 5;
  localparam int unsigned AE    = 1;
  localparam int unsigned W     = DW * NC;
  localparam int unsigned LW    = lvl_w_f(DEPTH);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_req = 1'b0;
  logic         rd_req = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] data_in = '0;

  logic [W-1:0]  s_data_out, f_data_out;
  logic          s_rd_valid, f_rd_valid, s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
  logic [LW-1:0] s_level, f_level;

  always #5 clk = ~clk;

  fifo_sync_mc #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .FWFT(FIFO_STD),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_std (
    .clk(clk), .rst(rst), .wr_req(wr_req), .data_in(data_in), .rd_req(rd_req),
    .data_out(s_data_out), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level), .overflow(s_ovf),
    .underflow(s_unf), .clr_err(clr_err)
  );

  fifo_sync_mc #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .FWFT(FIFO_FWFT),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_req(wr_req), .data_in(data_in), .rd_req(rd_req),
    .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level), .overflow(f_ovf),
    .underflow(f_unf), .clr_err(clr_err)
  );

  // Reference model: contents queue, pending standard-mode reads, sticky errors.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] s_last = '0;
  bit           m_ovf, m_unf, m_vld, started;
  int           tests = 0;
  int           fails = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    int n;
    if (started) begin
      n = mq.size();
      chk_int("std_level", int'(s_level), n);
      chk_int("fwft_level", int'(f_level), n);
      chk_bit("std_full", s_full, n == int'(DEPTH));
      chk_bit("fwft_full", f_full, n == int'(DEPTH));
      chk_bit("std_empty", s_empty, n == 0);
      chk_bit("fwft_empty", f_empty, n == 0);
      chk_bit("std_almost_full", s_af, n >= int'(AF));
      chk_bit("fwft_almost_full", f_af, n >= int'(AF));
      chk_bit("std_almost_empty", s_ae, n <= int'(AE));
      chk_bit("fwft_almost_empty", f_ae, n <= int'(AE));
      chk_bit("std_overflow", s_ovf, m_ovf);
      chk_bit("fwft_overflow", f_ovf, m_ovf);
      chk_bit("std_underflow", s_unf, m_unf);
      chk_bit("fwft_underflow", f_unf, m_unf);

      chk_bit("std_rd_valid", s_rd_valid, m_vld);
      if (s_rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL std_spurious_read: got data %h, expected no read", s_data_out);
        end else begin
          s_last = exp_q.pop_front();
          chk_w("std_data", s_data_out, s_last);
        end
      end else begin
        chk_w("std_data_hold", s_data_out, s_last);
      end

      chk_bit("fwft_rd_valid", f_rd_valid, n > 0);
      chk_w("fwft_data", f_data_out, (n > 0) ? mq[0] : '0);
    end
  end

  // Model update from the inputs seen at this rising edge.
  task automatic model_edge();
    bit fl, em, wa, ra;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_vld   = 1'b0;
      s_last  = '0;
      started = 1'b1;
    end else begin
      fl = (mq.size() == int'(DEPTH));
      em = (mq.size() == 0);
      wa = wr_req && !fl;
      ra = rd_req && !em;
      if (ra) exp_q.push_back(mq.pop_front());
      m_vld = ra;
      if (wa) mq.push_back(data_in);
      if (wr_req && fl) m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (rd_req && em) m_unf = 1'b1;
      else if (clr_err) m_unf = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [W-1:0] d, input bit rd,
                      input bit c);
    @(negedge clk);
    rst     = r;
    wr_req  = w;
    data_in = d;
    rd_req  = rd;
    clr_err = c;
    @(posedge clk);
    model_edge();
  endtask

  function automatic logic [W-1:0] rand_entry();
    logic [W-1:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v;
  endfunction

  initial begin
    int wp, rp;
    logic [W-1:0] rgb;
    rgb = {32'h333, 32'h222, 32'h111};

    step(1, 0, '0, 0, 0);
    step(1, 1, rand_entry(), 1, 0);
    repeat (3) step(0, 0, '0, 0, 0);

    // Fill to full, then an overflowing write and a full + both-request cycle.
    for (int i = 1; i <= int'(DEPTH); i++) step(0, 1, W'(i), 0, 0);
    step(0, 1, W'(32'h77), 0, 0);
    step(0, 1, W'(32'h88), 1, 0);
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < int'(DEPTH); i++) step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 1);

    // Lane placement, then reset mid-stream at level 3.
    step(0, 1, rgb, 0, 0);
    step(0, 1, rand_entry(), 0, 0);
    step(0, 1, rand_entry(), 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 1, rand_entry(), 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);

    // Single entry visible in FWFT without a request, then popped.
    step(0, 1, W'(32'hAA), 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 1);

    // Wrap twice with level held between 2 and 4.
    for (int i = 0; i < 3; i++) step(0, 1, rand_entry(), 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (mq.size() >= 4)      step(0, 0, '0, 1, 0);
      else if (mq.size() <= 2) step(0, 1, rand_entry(), 0, 0);
      else                     step(0, 1, rand_entry(), 1, 0);
    end

    // Randomised phases: fill-biased, drain-biased, balanced.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 150) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 50; rp = 50; end
      endcase
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < wp),
           rand_entry(),
           ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 99) < 3));
    end

    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    @(negedge clk);
    #1;
    chk_int("std_pending_reads", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
